// File: rtl/q_channel_controller_pkg.sv
// Shared types for the Q-channel controller: the FSM state encoding.
package q_channel_pkg;

   localparam logic [2:0] Q_DENIED_ENC = 3'd4;

   typedef enum logic [2:0] {
      Q_RUN     = 3'd0,
      Q_REQUEST = 3'd1,
      Q_STOPPED = 3'd2,
      Q_EXIT    = 3'd3,
      Q_DENIED  = Q_DENIED_ENC
   } state_t;

endpackage

// File: rtl/q_channel_controller_if.sv
// Q-channel signals between the power controller (master) and the device (slave).
interface q_channel_controller_if;
   logic qreqn_o;
   logic qacceptn_i;
   logic qactive_i;
   logic qdeny_i;

   modport master (output qreqn_o, input qacceptn_i, input qactive_i, input qdeny_i);
   modport slave  (input qreqn_o, output qacceptn_i, output qactive_i, output qdeny_i);
endinterface

// File: rtl/q_channel_controller_idle_counter.sv
// Saturating idle-period counter; expired is high once the count reaches IDLE_CYCLES-1.
module qc_idle_counter #(
   parameter int IDLE_CYCLES = 16,
   parameter int IDLE_W      = $clog2(IDLE_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clr,
   output logic [IDLE_W-1:0] count,
   output logic              expired
);

   localparam logic [IDLE_W-1:0] MAX_COUNT = IDLE_W'(IDLE_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= {IDLE_W{1'b0}};
      end else if (clr) begin
         count <= {IDLE_W{1'b0}};
      end else if (inc && (count != MAX_COUNT)) begin
         count <= count + IDLE_W'(1);
      end else begin
         count <= count;
      end
   end

   assign expired = (count == MAX_COUNT);

endmodule

// File: rtl/q_channel_controller.sv
// Q-channel initiator: auto-requests quiescence after an idle period and gates the device clock.
// Optional deny handling is compiled in with `define Q_DENY_EN.
module q_channel_controller
   import q_channel_pkg::*;
#(
   parameter int IDLE_CYCLES = 16,
   parameter int IDLE_W      = $clog2(IDLE_CYCLES + 1),
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en_i,
   q_channel_controller_if.master q,
   output logic                   clk_en_o,
   output logic [2:0]             state_o,
   output logic [CNT_W-1:0]       lp_entries_o
);

   state_t            state;
   state_t            next_state;
   logic              idle_inc;
   logic              idle_expired;
   logic [IDLE_W-1:0] idle_count;
   logic              lp_entry;

   // A device holding qacceptn low in RUN is misbehaving, so it never counts as idle.
   assign idle_inc = (state == Q_RUN) && !q.qactive_i && en_i && q.qacceptn_i;
   assign lp_entry = (state == Q_REQUEST) && (next_state == Q_STOPPED);
   assign state_o  = state;

   qc_idle_counter #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .IDLE_W      (IDLE_W)
   ) u_idle_counter (
      .clk     (clk),
      .reset   (reset),
      .inc     (idle_inc),
      .clr     (!idle_inc),
      .count   (idle_count),
      .expired (idle_expired)
   );

   always_comb begin
      next_state = state;
      case (state)
         Q_RUN: begin
            if (idle_inc && idle_expired) next_state = Q_REQUEST;
            else                          next_state = Q_RUN;
         end
         Q_REQUEST: begin
            // Accept takes priority over deny; a request is never withdrawn otherwise.
            if (!q.qacceptn_i)    next_state = Q_STOPPED;
`ifdef Q_DENY_EN
            else if (q.qdeny_i)   next_state = Q_DENIED;
`endif
            else                  next_state = Q_REQUEST;
         end
         Q_STOPPED: begin
            if (q.qactive_i || !en_i) next_state = Q_EXIT;
            else                      next_state = Q_STOPPED;
         end
         Q_EXIT: begin
            if (q.qacceptn_i) next_state = Q_RUN;
            else              next_state = Q_EXIT;
         end
         Q_DENIED: begin
`ifdef Q_DENY_EN
            if (!q.qdeny_i) next_state = Q_RUN;
            else            next_state = Q_DENIED;
`else
            next_state = Q_RUN;
`endif
         end
         default: next_state = Q_RUN;
      endcase
   end

   // Outputs are registered from next_state so they switch on the same edge as the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= Q_RUN;
         q.qreqn_o    <= 1'b1;
         clk_en_o     <= 1'b1;
         lp_entries_o <= {CNT_W{1'b0}};
      end else begin
         state     <= next_state;
         q.qreqn_o <= !((next_state == Q_REQUEST) || (next_state == Q_STOPPED));
         clk_en_o  <= (next_state != Q_STOPPED);
         if (lp_entry && (lp_entries_o != {CNT_W{1'b1}})) begin
            lp_entries_o <= lp_entries_o + CNT_W'(1);
         end else begin
            lp_entries_o <= lp_entries_o;
         end
      end
   end

endmodule
